sens_hispi_lane_merge: RTL and testbench

- Consumes the per-lane HiSPi cross-clock FIFOs in the pclk domain. There is one FIFO per lane, each exposing re/dout/run.
- Aligns lanes at line start, reads all lanes in lockstep and emits one parallel multi-lane pixel word per cycle, with sol/eol framing.
- Detects inter-lane start skew and length mismatch, flushes the offending FIFOs and flags errors to the status logic.
- Sits between the lane FIFOs and the sensor pixel pipeline (sens_parallel-style pxd/hact consumer).

---
 rtl/sens_hispi_pkg.sv | 16 +
 rtl/sens_hispi_lane_merge.sv | 152 +++++++++++++++
 tb/tb_sens_hispi_lane_merge.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sens_hispi_pkg.sv
// Shared HiSPi receive-path definitions: merge FSM state encoding and default lane geometry.
package sens_hispi_pkg;

  localparam int HISPI_NUM_LANES    = 4;
  localparam int HISPI_DATA_WIDTH   = 12;
  localparam int HISPI_SKEW_TIMEOUT = 15;
  localparam int HISPI_SKEW_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/sens_hispi_lane_merge.sv
// Merges the per-lane HiSPi FIFOs into one parallel pixel word per pclk, framing lines with
// sol/eol and flushing lanes whose start skew or line length disagree.
module sens_hispi_lane_merge
  import sens_hispi_pkg::*;
#(
  parameter int NUM_LANES    = HISPI_NUM_LANES,
  parameter int DATA_WIDTH   = HISPI_DATA_WIDTH,
  parameter int SKEW_TIMEOUT = HISPI_SKEW_TIMEOUT,
  parameter int LEN_WIDTH    = 14
) (
  input  logic                            pclk,
  input  logic                            prst_n,
  input  logic                            en,
  input  logic [NUM_LANES-1:0]            lane_run,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_dout,
  output logic [NUM_LANES-1:0]            lane_re,
  output logic [NUM_LANES*DATA_WIDTH-1:0] pxd,
  output logic                            dv,
  output logic                            sol,
  output logic                            eol,
  output logic                            err_skew,
  output logic                            err_len,
  output logic [LEN_WIDTH-1:0]            last_len
);

  localparam int PW = NUM_LANES * DATA_WIDTH;

  state_e                  state_q, state_d;
  logic [HISPI_SKEW_W-1:0] skew_cnt_q, skew_cnt_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    last_len_q, last_len_d;
  logic [PW-1:0]           pxd_q, pxd_d;
  logic                    first_q, first_d;
  logic                    dv_q, dv_d;
  logic                    sol_q, sol_d;
  logic                    err_skew_q, err_skew_d;
  logic                    err_len_q, err_len_d;
  logic [NUM_LANES-1:0]    re_d;
  logic                    any_run, all_run;

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (&v) ? v : v + LEN_WIDTH'(1);
  endfunction

  assign any_run = |lane_run;
  assign all_run = &lane_run;

  always_comb begin
    state_d    = state_q;
    skew_cnt_d = skew_cnt_q;
    cnt_d      = cnt_q;
    last_len_d = last_len_q;
    pxd_d      = pxd_q;
    first_d    = first_q;
    dv_d       = 1'b0;
    sol_d      = 1'b0;
    err_skew_d = 1'b0;
    err_len_d  = 1'b0;
    re_d       = '0;
    case (state_q)
      IDLE: begin
        // Disabled merge still drains the FIFOs so the lanes never stall.
        if (!en) begin
          re_d = lane_run;
        end else if (any_run) begin
          if (all_run) begin
            state_d = RUN;
            first_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d    = ALIGN;
            skew_cnt_d = '0;
          end
        end
      end
      ALIGN: begin
        skew_cnt_d = skew_cnt_q + HISPI_SKEW_W'(1);
        if (all_run) begin
          state_d = RUN;
          first_d = 1'b1;
          cnt_d   = '0;
        end else if (!any_run) begin
          state_d = IDLE;
        end else if (skew_cnt_q == HISPI_SKEW_W'(SKEW_TIMEOUT)) begin
          err_skew_d = 1'b1;
          state_d    = FLUSH;
        end
      end
      RUN: begin
        if (all_run) begin
          re_d    = '1;
          dv_d    = 1'b1;
          pxd_d   = lane_dout;
          sol_d   = first_q;
          first_d = 1'b0;
          cnt_d   = sat_inc(cnt_q);
        end else begin
          // cnt_q already includes the word still in flight on pxd this cycle.
          last_len_d = cnt_q;
          if (any_run) begin
            err_len_d = 1'b1;
            state_d   = FLUSH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        re_d = lane_run;
        if (!any_run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q    <= IDLE;
      skew_cnt_q <= '0;
      cnt_q      <= '0;
      last_len_q <= '0;
      pxd_q      <= '0;
      first_q    <= 1'b0;
      dv_q       <= 1'b0;
      sol_q      <= 1'b0;
      err_skew_q <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      skew_cnt_q <= skew_cnt_d;
      cnt_q      <= cnt_d;
      last_len_q <= last_len_d;
      pxd_q      <= pxd_d;
      first_q    <= first_d;
      dv_q       <= dv_d;
      sol_q      <= sol_d;
      err_skew_q <= err_skew_d;
      err_len_q  <= err_len_d;
    end
  end

  // Line end is only visible when run drops, i.e. while the final word is already on pxd.
  assign eol      = dv_q & (state_q == RUN) & ~all_run;
  assign lane_re  = prst_n ? re_d : '0;
  assign pxd      = pxd_q;
  assign dv       = dv_q;
  assign sol      = sol_q;
  assign err_skew = err_skew_q;
  assign err_len  = err_len_q;
  assign last_len = last_len_q;

endmodule

// File: tb/tb_sens_hispi_lane_merge.sv
// Directed bench for sens_hispi_lane_merge: show-ahead lane FIFO models feed the DUT and a
// scoreboard of expected merged words is compared against every dv.
module tb_sens_hispi_lane_merge;

  localparam int NL = 4;
  localparam int DW = 12;
  localparam int LW = 14;

  logic               pclk = 1'b0;
  logic               prst_n;
  logic               en;
  logic [NL-1:0]      lane_run = '0;
  logic [NL*DW-1:0]   lane_dout = '0;
  logic [NL-1:0]      lane_re;
  logic [NL*DW-1:0]   pxd;
  logic               dv, sol, eol, err_skew, err_len;
  logic [LW-1:0]      last_len;

  typedef struct packed {
    logic [NL*DW-1:0] pxd;
    logic             sol;
    logic             eol;
  } exp_t;

  exp_t        exp_q[$];
  logic [DW-1:0] mem [NL][64];
  logic [5:0]  rd [NL] = '{default: 6'd0};
  logic [5:0]  wr [NL] = '{default: 6'd0};

  int n_chk = 0;
  int n_fail = 0;
  int dv_seen = 0, eol_seen = 0, skew_seen = 0, len_seen = 0;

  sens_hispi_lane_merge dut (
    .pclk     (pclk),
    .prst_n   (prst_n),
    .en       (en),
    .lane_run (lane_run),
    .lane_dout(lane_dout),
    .lane_re  (lane_re),
    .pxd      (pxd),
    .dv       (dv),
    .sol      (sol),
    .eol      (eol),
    .err_skew (err_skew),
    .err_len  (err_len),
    .last_len (last_len)
  );

  initial forever #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] wv(input int line, input int lane, input int k);
    return {line[3:0], lane[3:0], k[3:0]};
  endfunction

  // Lane FIFO model: head word shown on dout while run is high, popped by re at the edge.
  always @(posedge pclk) begin : fifo_model
    logic [NL-1:0] re_s;
    re_s = lane_re;
    for (int i = 0; i < NL; i++)
      if (re_s[i]) chk("re_while_run_low", {63'd0, lane_run[i]}, 64'd1);
    #1;
    for (int i = 0; i < NL; i++) begin
      if (re_s[i] && rd[i] != wr[i]) rd[i] = rd[i] + 6'd1;
      lane_run[i] = (rd[i] != wr[i]);
      lane_dout[i*DW +: DW] = mem[i][rd[i]];
    end
  end

  always @(negedge pclk) begin : monitor
    exp_t e;
    skew_seen += int'(err_skew);
    len_seen  += int'(err_len);
    if (dv) begin
      dv_seen++;
      eol_seen += int'(eol);
      if (exp_q.size() == 0) begin
        chk("unexpected_dv", {63'd0, dv}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pxd", {16'd0, pxd}, {16'd0, e.pxd});
        chk("sol", {63'd0, sol}, {63'd0, e.sol});
        chk("eol", {63'd0, eol}, {63'd0, e.eol});
      end
    end else begin
      chk("framing_without_dv", {62'd0, sol, eol}, 64'd0);
    end
  end

  task automatic load(input int lane, input int line, input int n);
    for (int k = 0; k < n; k++) begin
      mem[lane][wr[lane]] = wv(line, lane, k);
      wr[lane] = wr[lane] + 6'd1;
    end
  endtask

  task automatic expect_words(input int line, input int n, input bit with_eol);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      for (int l = 0; l < NL; l++) e.pxd[l*DW +: DW] = wv(line, l, k);
      e.sol = (k == 0);
      e.eol = with_eol && (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NL; i++) if (rd[i] != wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag);
    int c;
    c = 0;
    while (c < 200 && !all_empty()) begin
      @(negedge pclk);
      c++;
    end
    chk({tag, "_drain_bound"}, {63'd0, c < 200}, 64'd1);
    repeat (4) @(negedge pclk);
  endtask

  initial begin
    int dv0, eol0, skew0, len0, c;
    prst_n = 1'b0;
    en     = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_lane_re", {60'd0, lane_re}, 64'd0);
    chk("rst_pxd", {16'd0, pxd}, 64'd0);
    chk("rst_flags", {59'd0, dv, sol, eol, err_skew, err_len}, 64'd0);
    chk("rst_last_len", {50'd0, last_len}, 64'd0);
    prst_n = 1'b1;
    en     = 1'b1;
    repeat (2) @(negedge pclk);

    // Aligned line of 8 words.
    dv0 = dv_seen; eol0 = eol_seen; skew0 = skew_seen; len0 = len_seen;
    for (int l = 0; l < NL; l++) load(l, 1, 8);
    expect_words(1, 8, 1'b1);
    drain("aligned");
    chk("aligned_dv_count", dv_seen - dv0, 8);
    chk("aligned_eol_count", eol_seen - eol0, 1);
    chk("aligned_last_len", {50'd0, last_len}, 64'd8);
    chk("aligned_no_err", (skew_seen - skew0) + (len_seen - len0), 0);

    // Lane 3 starts 5 cycles late, inside the skew window.
    dv0 = dv_seen; skew0 = skew_seen;
    for (int l = 0; l < 3; l++) load(l, 2, 8);
    repeat (5) @(negedge pclk);
    load(3, 2, 8);
    expect_words(2, 8, 1'b1);
    drain("skewed");
    chk("skewed_dv_count", dv_seen - dv0, 8);
    chk("skewed_no_err_skew", skew_seen - skew0, 0);
    chk("skewed_last_len", {50'd0, last_len}, 64'd8);

    // Lane 2 never starts: timeout, flush, no output.
    dv0 = dv_seen; skew0 = skew_seen;
    load(0, 3, 8); load(1, 3, 8); load(3, 3, 8);
    drain("timeout");
    chk("timeout_err_skew", skew_seen - skew0, 1);
    chk("timeout_no_dv", dv_seen - dv0, 0);
    chk("timeout_last_len_kept", {50'd0, last_len}, 64'd8);

    // Lane 1 ends after 6 words, others carry 8.
    dv0 = dv_seen; len0 = len_seen; eol0 = eol_seen;
    load(0, 4, 8); load(1, 4, 6); load(2, 4, 8); load(3, 4, 8);
    expect_words(4, 6, 1'b1);
    drain("short_lane");
    chk("short_dv_count", dv_seen - dv0, 6);
    chk("short_err_len", len_seen - len0, 1);
    chk("short_eol_count", eol_seen - eol0, 1);
    chk("short_last_len", {50'd0, last_len}, 64'd6);

    // Single-word line.
    dv0 = dv_seen;
    for (int l = 0; l < NL; l++) load(l, 5, 1);
    expect_words(5, 1, 1'b1);
    drain("one_word");
    chk("one_word_dv_count", dv_seen - dv0, 1);
    chk("one_word_last_len", {50'd0, last_len}, 64'd1);

    // Reset in the middle of a line after the 4th word.
    dv0 = dv_seen;
    for (int l = 0; l < NL; l++) load(l, 6, 8);
    expect_words(6, 4, 1'b0);
    c = 0;
    while (dv_seen < dv0 + 4 && c < 60) begin
      @(negedge pclk);
      #1;
      c++;
    end
    chk("midline_reached_word4", {63'd0, c < 60}, 64'd1);
    prst_n = 1'b0;
    en     = 1'b0;
    #1;
    chk("midrst_lane_re", {60'd0, lane_re}, 64'd0);
    chk("midrst_pxd", {16'd0, pxd}, 64'd0);
    chk("midrst_flags", {59'd0, dv, sol, eol, err_skew, err_len}, 64'd0);
    chk("midrst_last_len", {50'd0, last_len}, 64'd0);
    repeat (2) @(negedge pclk);
    prst_n = 1'b1;
    drain("residual_flush");
    chk("residual_no_dv", dv_seen - dv0, 4);
    chk("residual_sb_empty", exp_q.size(), 0);

    // Clean line after recovery.
    en  = 1'b1;
    dv0 = dv_seen;
    @(negedge pclk);
    for (int l = 0; l < NL; l++) load(l, 7, 8);
    expect_words(7, 8, 1'b1);
    drain("recovered");
    chk("recovered_dv_count", dv_seen - dv0, 8);
    chk("recovered_last_len", {50'd0, last_len}, 64'd8);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
